mult8x8_ctrl: RTL and testbench

Sequencing controller for the 8x8 shift-and-add multiplier datapath: one 4x4 multiplier, a shifter and a 16-bit clear/enable accumulator register. On a `start` request it walks the four nibble partial products through the datapath in four cycles. It drives the nibble-select, shift-select and accumulator enable/clear controls, then flags `done` for one cycle. It also detects `start` re-asserted mid-operation and parks in an error state until restarted.

---
 rtl/mult8x8_ctrl_if.sv | 37 +++
 rtl/mult8x8_ctrl.sv | 100 ++++++++++
 tb/tb_mult8x8_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mult8x8_ctrl_if.sv
// Control bundle between the 8x8 shift-and-add multiplier sequencer and its requester/datapath.
// The slave modport is the sequencer; the master side issues start and observes the controls.
interface mult8x8_ctrl_if;
  logic       start;
  logic [1:0] input_sel;
  logic [1:0] shift_sel;
  logic       acc_ena;
  logic       acc_sclr_n;
  logic       busy;
  logic       done;
  logic       err;
  logic [2:0] state_out;

  modport slave (
    input  start,
    output input_sel,
    output shift_sel,
    output acc_ena,
    output acc_sclr_n,
    output busy,
    output done,
    output err,
    output state_out
  );

  modport master (
    output start,
    input  input_sel,
    input  shift_sel,
    input  acc_ena,
    input  acc_sclr_n,
    input  busy,
    input  done,
    input  err,
    input  state_out
  );
endinterface

// File: rtl/mult8x8_ctrl.sv
// Sequencer for the 8x8 shift-and-add multiplier: walks four nibble partial products through a
// 4x4 multiplier, shifter and accumulator, pulses done, and traps start re-asserted mid-operation.
module mult8x8_ctrl (
  input  logic          clk,
  input  logic          aclr_n,
  mult8x8_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLsb  = 3'd1,
    StMid  = 3'd2,
    StMsb  = 3'd3,
    StDone = 3'd4,
    StErr  = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       mid_cnt_q, mid_cnt_d;
  logic [1:0] input_sel, shift_sel;
  logic       acc_ena, acc_sclr_n, busy, done, err;
  logic       accept;

  // The Mealy clear must stay quiet while reset is held, even if start is toggling.
  assign accept = bus.start & aclr_n;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= StIdle;
      mid_cnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mid_cnt_q <= mid_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mid_cnt_d  = 1'b0;
    input_sel  = 2'd0;
    shift_sel  = 2'd0;
    acc_ena    = 1'b0;
    acc_sclr_n = 1'b1;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state_q)
      StIdle, StErr: begin
        err = (state_q == StErr);
        if (accept) begin
          acc_ena    = 1'b1;
          acc_sclr_n = 1'b0;
          state_d    = StLsb;
        end
      end
      StLsb: begin
        acc_ena = 1'b1;
        busy    = 1'b1;
        state_d = bus.start ? StErr : StMid;
      end
      StMid: begin
        input_sel = mid_cnt_q ? 2'd2 : 2'd1;
        shift_sel = 2'd1;
        acc_ena   = 1'b1;
        busy      = 1'b1;
        if (bus.start) begin
          state_d = StErr;
        end else if (!mid_cnt_q) begin
          state_d   = StMid;
          mid_cnt_d = 1'b1;
        end else begin
          state_d = StMsb;
        end
      end
      StMsb: begin
        input_sel = 2'd3;
        shift_sel = 2'd2;
        acc_ena   = 1'b1;
        busy      = 1'b1;
        state_d   = bus.start ? StErr : StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.input_sel  = input_sel;
  assign bus.shift_sel  = shift_sel;
  assign bus.acc_ena    = acc_ena;
  assign bus.acc_sclr_n = acc_sclr_n;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.err        = err;
  assign bus.state_out  = state_q;

endmodule

// File: tb/tb_mult8x8_ctrl.sv
// Bench for mult8x8_ctrl: behavioural datapath around the controller, a cycle-count reference
// model for the control outputs, a product table, hand-written corner sequences and random start.
module tb_mult8x8_ctrl;

  logic clk;
  logic aclr_n;

  mult8x8_ctrl_if bus ();

  mult8x8_ctrl u_dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: 4x4 multiplier, shifter, 16-bit enable/clear accumulator.
  logic [7:0]  op_a, op_b;
  logic [3:0]  nib_a, nib_b;
  logic [7:0]  pp;
  logic [15:0] shifted;
  logic [15:0] acc;

  always_comb begin
    nib_a = bus.input_sel[1] ? op_a[7:4] : op_a[3:0];
    nib_b = bus.input_sel[0] ? op_b[7:4] : op_b[3:0];
    pp    = nib_a * nib_b;
    case (bus.shift_sel)
      2'd1:    shifted = {4'd0, pp, 4'd0};
      2'd2:    shifted = {pp, 8'd0};
      default: shifted = {8'd0, pp};
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.acc_ena) begin
      acc <= bus.acc_sclr_n ? acc + shifted : 16'd0;
    end
  end

  // Reference model: m_phase counts cycles since an accepted start (0 = idle, 1..4 busy, 5 done).
  int          m_phase;
  bit          m_err;
  logic [15:0] exp_prod;
  int          checks;
  int          errors;
  int          cyc;

  function automatic logic [11:0] exp_vec(bit s, bit rn);
    logic [2:0] st;
    logic [1:0] isel, ssel;
    bit         ena, scl, bsy, dn, er;
    st = 3'd0; isel = 2'd0; ssel = 2'd0;
    ena = 1'b0; scl = 1'b1; bsy = 1'b0; dn = 1'b0; er = 1'b0;
    if (rn) begin
      if (m_err || m_phase == 0) begin
        st  = m_err ? 3'd5 : 3'd0;
        er  = m_err;
        ena = s;
        scl = !s;
      end else if (m_phase <= 4) begin
        isel = 2'(m_phase - 1);
        ssel = (m_phase == 1) ? 2'd0 : (m_phase == 4) ? 2'd2 : 2'd1;
        st   = (m_phase == 1) ? 3'd1 : (m_phase == 4) ? 3'd3 : 3'd2;
        ena  = 1'b1;
        bsy  = 1'b1;
      end else begin
        st = 3'd4;
        dn = 1'b1;
      end
    end
    return {st, isel, ssel, ena, scl, bsy, dn, er};
  endfunction

  task automatic model_update(bit s, bit rn);
    if (!rn) begin
      m_phase = 0;
      m_err   = 1'b0;
    end else if (m_err || m_phase == 0) begin
      if (s) begin
        m_phase = 1;
        m_err   = 1'b0;
      end
    end else if (m_phase <= 4) begin
      if (s) begin
        m_err   = 1'b1;
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end else begin
      m_phase = 0;
    end
  endtask

  // One clock cycle: drive at negedge, check just after, then advance the model past the edge.
  task automatic step(bit s, bit rn, string tag);
    logic [11:0] act, want;
    @(negedge clk);
    aclr_n    = rn;
    bus.start = s;
    #1;
    act  = {bus.state_out, bus.input_sel, bus.shift_sel, bus.acc_ena, bus.acc_sclr_n,
            bus.busy, bus.done, bus.err};
    want = exp_vec(s, rn);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s ctrl cyc=%0d got=%h want=%h", tag, cyc, act, want);
    end
    if (rn && !m_err && m_phase == 5) begin
      checks++;
      if (acc !== exp_prod) begin
        errors++;
        $display("FAIL %s product cyc=%0d got=%h want=%h", tag, cyc, acc, exp_prod);
      end
    end
    @(posedge clk);
    #1;
    model_update(s, rn);
    cyc++;
  endtask

  task automatic run_mult(logic [7:0] a, logic [7:0] b, logic [15:0] p, string tag);
    op_a     = a;
    op_b     = b;
    exp_prod = p;
    step(1'b1, 1'b1, tag);
    repeat (5) step(1'b0, 1'b1, tag);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t tbl[6];

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    m_phase   = 0;
    m_err     = 1'b0;
    exp_prod  = 16'd0;
    op_a      = 8'd0;
    op_b      = 8'd0;
    aclr_n    = 1'b0;
    bus.start = 1'b0;

    tbl[0] = '{a: 8'hFF, b: 8'hFF, prod: 16'hFE01};
    tbl[1] = '{a: 8'h00, b: 8'hA5, prod: 16'h0000};
    tbl[2] = '{a: 8'h12, b: 8'h34, prod: 16'h03A8};
    tbl[3] = '{a: 8'h0F, b: 8'hF0, prod: 16'h0E10};
    tbl[4] = '{a: 8'h80, b: 8'h02, prod: 16'h0100};
    tbl[5] = '{a: 8'hA5, b: 8'h5A, prod: 16'h3A02};

    // Reset state, including start toggling under reset.
    step(1'b0, 1'b0, "reset");
    step(1'b1, 1'b0, "reset");
    step(1'b0, 1'b1, "reset_rel");

    for (int i = 0; i < 6; i++) begin
      run_mult(tbl[i].a, tbl[i].b, tbl[i].prod, "table");
    end

    // Reset asserted during MID with start pulsing; then a clean multiply.
    op_a = 8'h12; op_b = 8'h34; exp_prod = 16'h03A8;
    step(1'b1, 1'b1, "rst_mid");
    step(1'b0, 1'b1, "rst_mid");
    step(1'b0, 1'b1, "rst_mid");
    step(1'b1, 1'b0, "rst_mid");
    step(1'b0, 1'b0, "rst_mid");
    step(1'b1, 1'b0, "rst_mid");
    step(1'b0, 1'b1, "rst_mid");
    run_mult(8'h12, 8'h34, 16'h03A8, "after_rst");

    // Error path: start again in MID0, linger in ERR, then restart.
    op_a = 8'hFF; op_b = 8'hFF; exp_prod = 16'hFE01;
    step(1'b1, 1'b1, "err_path");
    step(1'b0, 1'b1, "err_path");
    step(1'b1, 1'b1, "err_path");
    repeat (3) step(1'b0, 1'b1, "err_path");
    run_mult(8'hFF, 8'hFF, 16'hFE01, "err_recover");

    // Back-to-back: start in DONE ignored, then accepted in the following IDLE.
    op_a = 8'hFF; op_b = 8'hFF; exp_prod = 16'hFE01;
    step(1'b1, 1'b1, "b2b");
    repeat (4) step(1'b0, 1'b1, "b2b");
    step(1'b1, 1'b1, "b2b_done");
    run_mult(8'h0F, 8'hF0, 16'h0E10, "b2b_second");

    // Held start: ERR at C2, then ERR -> clear -> LSB -> ERR, never done.
    repeat (12) step(1'b1, 1'b1, "held");
    step(1'b0, 1'b1, "held");
    step(1'b0, 1'b1, "held");

    // Random start traffic with fresh operands whenever the model is idle or in error.
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 0 || m_err) begin
        op_a     = 8'($urandom);
        op_b     = 8'($urandom);
        exp_prod = 16'(op_a) * 16'(op_b);
      end
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 60) != 0), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
